// File: rtl/unidade_controle_rodadas.sv
// rtl/unidade_controle_rodadas.sv - Moore control unit for the round-based memory game
// Optional per-move timeout counter and esgotou state enabled by `define TIMEOUT_EN.
module unidade_controle_rodadas #(
  parameter int TIMEOUT = 5000,
  parameter int TW      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  if (TIMEOUT < 2 || (2 ** TW) <= TIMEOUT) begin : g_parametros_invalidos
    $error("unidade_controle_rodadas: need TIMEOUT >= 2 and 2**TW > TIMEOUT");
  end

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    ESGOTOU        = 4'hC,
    ERROU          = 4'hD,
    FIM_ACERTOU    = 4'hF
  } t_estado;

  t_estado r_estado;
  t_estado w_proximo;
  logic    w_esgotou;

`ifdef TIMEOUT_EN
  logic [TW-1:0] r_contador;

  assign w_esgotou = (r_contador == TW'(TIMEOUT - 1));

  // Cleared in every other state, so each espera visit restarts from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_contador <= '0;
    end else if (r_estado != ESPERA) begin
      r_contador <= '0;
    end else if (!w_esgotou) begin
      r_contador <= r_contador + 1'b1;
    end
  end
`else
  assign w_esgotou = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:        w_proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     w_proximo = INICIA_RODADA;
      INICIA_RODADA:  w_proximo = ESPERA;
      ESPERA: begin
        if (jogada)         w_proximo = REGISTRA;
        else if (w_esgotou) w_proximo = ESGOTOU;
        else                w_proximo = ESPERA;
      end
      REGISTRA:       w_proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)                    w_proximo = ERROU;
        else if (!enderecoIgualLimite) w_proximo = PROXIMA_JOGADA;
        else if (!fimL)                w_proximo = PROXIMA_RODADA;
        else                           w_proximo = FIM_ACERTOU;
      end
      PROXIMA_JOGADA: w_proximo = ESPERA;
      PROXIMA_RODADA: w_proximo = INICIA_RODADA;
`ifdef TIMEOUT_EN
      ESGOTOU:        w_proximo = iniciar ? PREPARACAO : ESGOTOU;
`endif
      ERROU:          w_proximo = iniciar ? PREPARACAO : ERROU;
      FIM_ACERTOU:    w_proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
      default:        w_proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    db_estado = r_estado;
    case (r_estado)
      INICIAL, PREPARACAO: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      INICIA_RODADA:  zeraE = 1'b1;
      ESPERA, COMPARACAO: ;
      REGISTRA:       registraR = 1'b1;
      PROXIMA_JOGADA: contaE = 1'b1;
      PROXIMA_RODADA: contaL = 1'b1;
`ifdef TIMEOUT_EN
      ESGOTOU: begin
        timeout = 1'b1;
        pronto  = 1'b1;
      end
`endif
      ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
      end
      FIM_ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
      end
      default: db_estado = 4'hE;
    endcase
  end

endmodule
